// File: rtl/uart_tx_sched.sv
// Round-robin arbiter sharing one 8N1 UART TX line among NREQ byte sources.
// The baud counter restarts at every frame start so that bit edges line up with the start bit.
module uart_tx_sched #(
  parameter int NREQ    = 4,
  parameter int CLK_DIV = 5208
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*8-1:0] data_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [2:0]        grant_id_o,
  output logic              busy_o,
  output logic              txd_o
);
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        gid_q, gid_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              txd_q, txd_d;

  logic              gnt_vld;
  logic [2:0]        gnt_idx;
  logic [7:0]        gnt_byte;
  logic [NREQ-1:0]   rq_sh;
  logic              bit_end;
  int                idx;

  // First requester at or above ptr+1, wrapping around NREQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rq_sh   = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + 1 + k;
      if (idx >= NREQ) idx = idx - NREQ;
      rq_sh = req_i >> idx;
      if (!gnt_vld && rq_sh[0]) begin
        gnt_vld = 1'b1;
        gnt_idx = 3'(idx);
      end
    end
    gnt_byte = 8'(data_i >> {gnt_idx, 3'b000});
  end

  assign bit_end = (baud_q == CW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    ack_d   = '0;
    txd_d   = txd_q;
    if (state_q == S_IDLE) begin
      txd_d = 1'b1;
      if (gnt_vld) begin
        ack_d   = NREQ'(1) << gnt_idx;
        gid_d   = gnt_idx;
        ptr_d   = gnt_idx;
        shift_d = gnt_byte;
        txd_d   = 1'b0;
        baud_d  = '0;
        state_d = S_START;
      end
    end else begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
      if (bit_end) begin
        case (state_q)
          S_START: begin
            state_d = S_DATA;
            bit_d   = '0;
            txd_d   = shift_q[0];
          end
          S_DATA: begin
            if (bit_q == 3'd7) begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end else begin
              bit_d   = bit_q + 3'd1;
              shift_d = shift_q >> 1;
              txd_d   = shift_q[1];
            end
          end
          default: begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ptr_q   <= 3'(NREQ - 1);
      gid_q   <= '0;
      ack_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      ack_q   <= ack_d;
      txd_q   <= txd_d;
    end
  end

  assign ack_o      = ack_q;
  assign grant_id_o = gid_q;
  assign busy_o     = (state_q != S_IDLE);
  assign txd_o      = txd_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus random traffic, with a per-cycle frame-timeline reference model.
module tb_uart_tx_sched;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  ack_o;
  logic [2:0]  grant_id_o;
  logic        busy_o, txd_o;

  int checks = 0, failures = 0, cyc = 0;
  int ack_t[$];
  int ack_g[$];

  uart_tx_sched #(.NREQ(4), .CLK_DIV(D)) dut (
    .clk(clk), .RSTn(RSTn), .req_i(req), .data_i(data),
    .ack_o(ack_o), .grant_id_o(grant_id_o), .busy_o(busy_o), .txd_o(txd_o)
  );

  always #5 clk = ~clk;

  // Reference: m_t is the cycle offset inside the current frame (-1 = idle line).
  int         m_t = -1, m_ptr = 3, m_gid = 0;
  logic [3:0] m_ack = '0;
  logic [7:0] m_byte = '0;

  always @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      m_t = -1; m_ptr = 3; m_gid = 0; m_ack = '0; m_byte = '0;
    end else if (m_t < 0) begin
      m_ack = '0;
      if (req != 0) begin
        for (int k = 1; k <= 4; k++) begin
          int i;
          i = (m_ptr + k) % 4;
          if (req[i]) begin
            m_ptr = i; m_gid = i; m_byte = data[8*i +: 8];
            m_ack = 4'(1 << i); m_t = 0;
            break;
          end
        end
      end
    end else begin
      m_ack = '0;
      m_t++;
      if (m_t == 10*D) m_t = -1;
    end
  end

  function automatic logic m_txd();
    int b;
    if (m_t < 0) return 1'b1;
    b = m_t / D;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("txd", 32'(txd_o), 32'(m_txd()));
    chk("busy", 32'(busy_o), 32'(m_t >= 0));
    chk("ack", 32'(ack_o), 32'(m_ack));
    chk("grant_id", 32'(grant_id_o), 32'(m_gid));
    if (ack_o != 0) begin
      ack_t.push_back(cyc);
      ack_g.push_back(int'(grant_id_o));
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic wait_ack(input string tag, input int lim);
    int n = 0;
    while (ack_o == 0 && n < lim) begin step(); n++; end
    chk(tag, 32'(ack_o != 0), 32'd1);
  endtask

  task automatic run_frame(input string tag, input logic [9:0] pat);
    int bc = 0;
    for (int j = 0; j < 10*D; j++) begin
      chk(tag, 32'(txd_o), 32'(pat[j/D]));
      if (busy_o) bc++;
      step();
    end
    chk({tag, "_busycnt"}, 32'(bc), 32'(10*D));
    chk({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  task automatic rst_pulse();
    RSTn = 1'b0;
    step(); step();
    RSTn = 1'b1;
  endtask

  initial begin
    int n;
    @(negedge clk);
    check_all();
    chk("rst_txd", 32'(txd_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_gid", 32'(grant_id_o), 32'd0);
    step();
    RSTn = 1'b1;

    // 1: single 0x55 frame
    req = 4'b0001; data = 32'h55;
    wait_ack("t1_ack", 5);
    chk("t1_ack0", 32'(ack_o), 32'h1);
    req = '0;
    run_frame("t1_txd", 10'b1010101010);

    // 2: all requesting, order 0,1,2,3,0 with 41-cycle period
    rst_pulse();
    ack_t.delete(); ack_g.delete();
    req = 4'hF; data = 32'hA3A2A1A0;
    repeat (5*(10*D+1) + 2) step();
    req = '0;
    repeat (10*D + 4) step();
    chk("t2_cnt", 32'(ack_g.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < ack_g.size(); k++) chk("t2_order", 32'(ack_g[k]), 32'(k % 4));
    for (int k = 0; k < 4 && k + 1 < ack_t.size(); k++) chk("t2_gap", 32'(ack_t[k+1] - ack_t[k]), 32'(10*D+1));

    // 3: req[1] and req[3] held -> alternation
    rst_pulse();
    ack_t.delete(); ack_g.delete();
    req = 4'b1010; data = 32'h33221100;
    repeat (4*(10*D+1) + 2) step();
    req = '0;
    repeat (10*D + 4) step();
    chk("t3_cnt", 32'(ack_g.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < ack_g.size(); k++) chk("t3_alt", 32'(ack_g[k]), (k % 2 == 0) ? 32'd1 : 32'd3);

    // 4: req[2] raised mid-frame waits for IDLE
    req = 4'b0001; data = 32'h000000C3;
    wait_ack("t4_ack0", 5);
    req = '0;
    repeat (5*D + 1) step();
    req = 4'b0100; data = 32'h00AB0000;
    n = 0;
    while (ack_o == 0 && n < 100) begin step(); n++; end
    chk("t4_wait", 32'(n), 32'(5*D));
    chk("t4_ack2", 32'(ack_o), 32'h4);
    req = '0;
    repeat (10*D + 2) step();

    // 5: reset in mid DATA aborts, then a fresh 0xFF frame
    req = 4'b0001; data = 32'h3C;
    wait_ack("t5_ack0", 5);
    req = '0;
    repeat (3*D + 1) step();
    RSTn = 1'b0;
    #1;
    chk("t5_txd_async", 32'(txd_o), 32'd1);
    chk("t5_busy_async", 32'(busy_o), 32'd0);
    step(); step();
    RSTn = 1'b1;
    req = 4'b0001; data = 32'hFF;
    wait_ack("t5_ack", 5);
    req = '0;
    run_frame("t5_txd", 10'b1111111110);

    // 6: one-cycle req[3] pulse
    step();
    req = 4'b1000; data = 32'h81000000;
    step();
    req = '0; data = '0;
    chk("t6_ack3", 32'(ack_o), 32'h8);
    run_frame("t6_txd", 10'b1100000010);
    repeat (5) step();
    chk("t6_gid_hold", 32'(grant_id_o), 32'd3);

    // random traffic, occasional async reset
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        req = 4'($urandom_range(0, 15));
        data = $urandom;
      end
      RSTn = ($urandom_range(0, 699) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
